// File: rtl/knn_ctrl.sv
// knn_ctrl -- run sequencer for the KNN sorter datapath.
//
// A start request latches the test point and the (saturated) point count,
// pulses a sorter clear, then walks the training memory from index 0 to
// n_eff-1. For every index it issues a one-cycle memory read, captures the
// returned {y,x} word and offers the (test, training) pair to the sorter with
// a valid/ready handshake. After the final pair it waits for srt_done (bounded
// by TIMEOUT cycles) and leaves sticky completion/error status behind.
//
// Ports
//   clk, rst (async, active-low), soft_rst (sync, active-high)
//   start, n_points, test_x, test_y        : run request and its arguments
//   busy, done, err_empty, err_timeout     : run status
//   count                                  : pairs accepted by the sorter
//   mem_en, mem_addr, mem_rdata            : training memory read port
//                                            (rdata valid 1 cycle after mem_en)
//   srt_clr                                : one-cycle sorter clear
//   srt_valid, srt_ready                   : pair handshake
//   srt_x1/srt_y1, srt_x2/srt_y2           : test point / training point
//   srt_idx, srt_last                      : training index, final-pair flag
//   srt_done                               : sorter finished last insertion
module knn_ctrl #(
  parameter int COORD_W    = 16,
  parameter int MEM_ADDR_W = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    soft_rst,
  input  logic                    start,
  input  logic [MEM_ADDR_W:0]     n_points,
  input  logic [COORD_W-1:0]      test_x,
  input  logic [COORD_W-1:0]      test_y,
  output logic                    busy,
  output logic                    done,
  output logic                    err_empty,
  output logic                    err_timeout,
  output logic [MEM_ADDR_W:0]     count,
  output logic                    mem_en,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  input  logic [2*COORD_W-1:0]    mem_rdata,
  output logic                    srt_clr,
  output logic                    srt_valid,
  input  logic                    srt_ready,
  output logic [COORD_W-1:0]      srt_x1,
  output logic [COORD_W-1:0]      srt_y1,
  output logic [COORD_W-1:0]      srt_x2,
  output logic [COORD_W-1:0]      srt_y2,
  output logic [MEM_ADDR_W-1:0]   srt_idx,
  output logic                    srt_last,
  input  logic                    srt_done
);

  localparam int N_W = MEM_ADDR_W + 1;
  // Largest point count the memory can hold: 2**MEM_ADDR_W.
  localparam logic [N_W-1:0]        MAX_POINTS = {1'b1, {MEM_ADDR_W{1'b0}}};
  localparam logic [N_W-1:0]        ONE_N      = {{MEM_ADDR_W{1'b0}}, 1'b1};
  localparam logic [MEM_ADDR_W-1:0] ONE_A      = {{(MEM_ADDR_W-1){1'b0}}, 1'b1};
  // DRAIN lasts at most TIMEOUT cycles; the timer value in the final allowed
  // cycle is TIMEOUT-1, and srt_done in that cycle still counts as success.
  localparam logic [7:0]            TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_READ,
    S_LOAD,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t                state_reg, state_next;
  logic [COORD_W-1:0]    x1_reg, x1_next;
  logic [COORD_W-1:0]    y1_reg, y1_next;
  logic [COORD_W-1:0]    x2_reg, x2_next;
  logic [COORD_W-1:0]    y2_reg, y2_next;
  logic [N_W-1:0]        n_eff_reg, n_eff_next;
  logic [MEM_ADDR_W-1:0] idx_reg, idx_next;
  logic [MEM_ADDR_W-1:0] sidx_reg, sidx_next;
  logic                  last_reg, last_next;
  logic [N_W-1:0]        count_reg, count_next;
  logic [7:0]            timer_reg, timer_next;
  logic                  done_reg, done_next;
  logic                  err_empty_reg, err_empty_next;
  logic                  err_timeout_reg, err_timeout_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      x1_reg          <= '0;
      y1_reg          <= '0;
      x2_reg          <= '0;
      y2_reg          <= '0;
      n_eff_reg       <= '0;
      idx_reg         <= '0;
      sidx_reg        <= '0;
      last_reg        <= 1'b0;
      count_reg       <= '0;
      timer_reg       <= '0;
      done_reg        <= 1'b0;
      err_empty_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      x1_reg          <= x1_next;
      y1_reg          <= y1_next;
      x2_reg          <= x2_next;
      y2_reg          <= y2_next;
      n_eff_reg       <= n_eff_next;
      idx_reg         <= idx_next;
      sidx_reg        <= sidx_next;
      last_reg        <= last_next;
      count_reg       <= count_next;
      timer_reg       <= timer_next;
      done_reg        <= done_next;
      err_empty_reg   <= err_empty_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    x1_next          = x1_reg;
    y1_next          = y1_reg;
    x2_next          = x2_reg;
    y2_next          = y2_reg;
    n_eff_next       = n_eff_reg;
    idx_next         = idx_reg;
    sidx_next        = sidx_reg;
    last_next        = last_reg;
    count_next       = count_reg;
    timer_next       = timer_reg;
    done_next        = done_reg;
    err_empty_next   = err_empty_reg;
    err_timeout_next = err_timeout_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          x1_next          = test_x;
          y1_next          = test_y;
          n_eff_next       = (n_points > MAX_POINTS) ? MAX_POINTS : n_points;
          done_next        = 1'b0;
          err_empty_next   = 1'b0;
          err_timeout_next = 1'b0;
          count_next       = '0;
          idx_next         = '0;
          state_next       = S_CLR;
        end
      end

      S_CLR: begin
        if (n_eff_reg == '0) begin
          err_empty_next = 1'b1;
          done_next      = 1'b1;
          state_next     = S_IDLE;
        end else begin
          state_next = S_READ;
        end
      end

      S_READ: begin
        state_next = S_LOAD;
      end

      S_LOAD: begin
        // Read data for idx_reg is on mem_rdata in this cycle.
        x2_next    = mem_rdata[COORD_W-1:0];
        y2_next    = mem_rdata[2*COORD_W-1:COORD_W];
        sidx_next  = idx_reg;
        last_next  = ({1'b0, idx_reg} == (n_eff_reg - ONE_N));
        state_next = S_ISSUE;
      end

      S_ISSUE: begin
        if (srt_ready) begin
          count_next = count_reg + ONE_N;
          if (last_reg) begin
            timer_next = '0;
            state_next = S_DRAIN;
          end else begin
            // Only advanced when another point follows, so idx never wraps.
            idx_next   = idx_reg + ONE_A;
            state_next = S_READ;
          end
        end
      end

      S_DRAIN: begin
        if (srt_done) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else if (timer_reg == TIMER_LAST) begin
          err_timeout_next = 1'b1;
          done_next        = 1'b1;
          state_next       = S_IDLE;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Soft reset wins over everything, including a same-cycle start.
    if (soft_rst) begin
      state_next       = S_IDLE;
      x1_next          = '0;
      y1_next          = '0;
      x2_next          = '0;
      y2_next          = '0;
      n_eff_next       = '0;
      idx_next         = '0;
      sidx_next        = '0;
      last_next        = 1'b0;
      count_next       = '0;
      timer_next       = '0;
      done_next        = 1'b0;
      err_empty_next   = 1'b0;
      err_timeout_next = 1'b0;
    end
  end

  // Strobes decode directly from the state register so an asynchronous reset
  // clears them without waiting for a clock edge.
  assign busy        = (state_reg != S_IDLE);
  assign srt_clr     = (state_reg == S_CLR);
  assign mem_en      = (state_reg == S_READ);
  assign srt_valid   = (state_reg == S_ISSUE);
  assign mem_addr    = idx_reg;
  assign done        = done_reg;
  assign err_empty   = err_empty_reg;
  assign err_timeout = err_timeout_reg;
  assign count       = count_reg;
  assign srt_x1      = x1_reg;
  assign srt_y1      = y1_reg;
  assign srt_x2      = x2_reg;
  assign srt_y2      = y2_reg;
  assign srt_idx     = sidx_reg;
  assign srt_last    = last_reg;

endmodule

// File: tb/tb_knn_ctrl.sv
// Testbench for knn_ctrl: directed runs against a run-level model of the
// sequencer (expected pair stream, final status and busy duration computed
// from the point count, stall length and sorter done delay).
module tb_knn_ctrl;
  localparam int CW   = 16;
  localparam int AW   = 10;
  localparam int TO   = 255;
  localparam int NMAX = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          soft_rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   n_points = '0;
  logic [CW-1:0] test_x = '0;
  logic [CW-1:0] test_y = '0;
  logic          busy, done, err_empty, err_timeout;
  logic [AW:0]   count;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [2*CW-1:0] mem_rdata = '0;
  logic          srt_clr, srt_valid;
  logic          srt_ready = 1'b1;
  logic [CW-1:0] srt_x1, srt_y1, srt_x2, srt_y2;
  logic [AW-1:0] srt_idx;
  logic          srt_last;
  logic          srt_done = 1'b0;

  always #5 clk = ~clk;

  knn_ctrl #(.COORD_W(CW), .MEM_ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .start(start),
    .n_points(n_points), .test_x(test_x), .test_y(test_y),
    .busy(busy), .done(done), .err_empty(err_empty), .err_timeout(err_timeout),
    .count(count), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .srt_clr(srt_clr), .srt_valid(srt_valid), .srt_ready(srt_ready),
    .srt_x1(srt_x1), .srt_y1(srt_y1), .srt_x2(srt_x2), .srt_y2(srt_y2),
    .srt_idx(srt_idx), .srt_last(srt_last), .srt_done(srt_done)
  );

  // Training memory with one-cycle registered read.
  logic [2*CW-1:0] mem [NMAX];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Run parameters, written only by the main process.
  int            run_eff = 0;
  logic [CW-1:0] run_tx = '0;
  logic [CW-1:0] run_ty = '0;
  int            stall_idx = -1;
  int            stall_len = 0;
  int            done_delay = 0;

  // Model state, written only by the compare process.
  int m_xfers = 0;
  int busy_cnt = 0;
  int clr_cnt = 0;
  int memen_cnt = 0;
  bit prev_busy = 1'b0;

  always @(negedge clk) begin
    logic [2*CW-1:0] w;
    if (!rst) begin
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_valid", 64'(srt_valid), 64'(0));
      chk("arst_count", 64'(count), 64'(0));
      m_xfers   = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        m_xfers = 0; busy_cnt = 0; clr_cnt = 0; memen_cnt = 0;
      end
      if (!busy) begin
        chk("idle_clr", 64'(srt_clr), 64'(0));
        chk("idle_valid", 64'(srt_valid), 64'(0));
        chk("idle_mem_en", 64'(mem_en), 64'(0));
      end
      if (mem_en) chk("mem_addr", 64'(mem_addr), 64'(m_xfers));
      if (srt_valid) begin
        w = mem[m_xfers];
        chk("pair_x1", 64'(srt_x1), 64'(run_tx));
        chk("pair_y1", 64'(srt_y1), 64'(run_ty));
        chk("pair_x2", 64'(srt_x2), 64'(w[CW-1:0]));
        chk("pair_y2", 64'(srt_y2), 64'(w[2*CW-1:CW]));
        chk("pair_idx", 64'(srt_idx), 64'(m_xfers));
        chk("pair_last", 64'(srt_last), 64'(m_xfers == run_eff - 1));
      end
      chk("count", 64'(count), 64'(m_xfers));
      if (busy) busy_cnt++;
      if (srt_clr) clr_cnt++;
      if (mem_en) memen_cnt++;
      if (soft_rst) m_xfers = 0;
      else if (srt_valid && srt_ready) m_xfers++;
      prev_busy = busy;
    end
  end

  // Sorter ready: stalls stall_len cycles on the pair with index stall_idx.
  int stall_cnt = 0;
  always begin
    @(posedge clk); #1;
    if (srt_clr) stall_cnt = 0;
    if (srt_valid && int'(srt_idx) == stall_idx && stall_cnt < stall_len) begin
      srt_ready = 1'b0;
      stall_cnt++;
    end else begin
      srt_ready = 1'b1;
    end
  end

  // Sorter done: one-cycle pulse done_delay cycles into DRAIN (never if < 0).
  always begin
    @(negedge clk);
    if (rst && srt_valid && srt_ready && srt_last && done_delay >= 0) begin
      @(posedge clk);
      repeat (done_delay) @(posedge clk);
      #1 srt_done = 1'b1;
      @(posedge clk);
      #1 srt_done = 1'b0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'({err_empty, err_timeout}), 64'(0));
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_strobes"}, 64'({srt_clr, srt_valid, mem_en}), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_pair"}, {srt_x1, srt_y1, srt_x2, srt_y2}, 64'(0));
    chk({tag, "_idx_last"}, 64'({srt_idx, srt_last}), 64'(0));
  endtask

  task automatic fill_mem(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      mem[i] = rnd ? 32'($urandom) : {16'(2 * i + 2), 16'(2 * i + 1)};
  endtask

  task automatic begin_run(input int n, input logic [CW-1:0] tx, input logic [CW-1:0] ty,
                           input int s_idx, input int s_len, input int dd);
    run_eff = (n > NMAX) ? NMAX : n;
    run_tx = tx; run_ty = ty;
    stall_idx = s_idx; stall_len = s_len; done_delay = dd;
    @(posedge clk); #1;
    n_points = n[AW:0]; test_x = tx; test_y = ty; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n_points = '0; test_x = ~tx; test_y = ~ty;
  endtask

  task automatic run(input string tag, input int n, input logic [CW-1:0] tx,
                     input logic [CW-1:0] ty, input int s_idx, input int s_len,
                     input int dd, input bit poke, output int busy_seen);
    int drain, exp_busy;
    bit ok_done, poked;
    begin_run(n, tx, ty, s_idx, s_len, dd);
    chk({tag, "_start_busy"}, 64'(busy), 64'(1));
    chk({tag, "_start_flags"}, 64'({done, err_empty, err_timeout}), 64'(0));
    poked = 1'b0;
    for (int c = 0; c < 5000 && busy; c++) begin
      if (poke && !poked && srt_valid && srt_idx == 1) begin
        start = 1'b1; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "_finished"}, 64'(busy), 64'(0));
    @(negedge clk);
    ok_done  = (dd >= 0) && (dd + 1 <= TO);
    drain    = ok_done ? dd + 1 : TO;
    exp_busy = 1 + ((run_eff == 0) ? 0 :
               3 * run_eff + ((s_idx >= 0 && s_idx < run_eff) ? s_len : 0) + drain);
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_err_empty"}, 64'(err_empty), 64'(run_eff == 0));
    chk({tag, "_err_timeout"}, 64'(err_timeout), 64'(run_eff > 0 && !ok_done));
    chk({tag, "_count"}, 64'(count), 64'(run_eff));
    chk({tag, "_xfers"}, 64'(m_xfers), 64'(run_eff));
    chk({tag, "_clr_pulses"}, 64'(clr_cnt), 64'(1));
    chk({tag, "_reads"}, 64'(memen_cnt), 64'(run_eff));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    $display("run %s: n=%0d count=%0d busy_cycles=%0d done=%0d err_empty=%0d err_timeout=%0d",
             tag, n, count, busy_cnt, done, err_empty, err_timeout);
    busy_seen = busy_cnt;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int b;
    bit found;
    #2 rst = 1'b0;
    #20 check_zero("reset");
    @(posedge clk); #1 rst = 1'b1;

    fill_mem(4, 1'b0);
    run("basic", 4, 16'd10, 16'd20, -1, 0, 2, 1'b0, b);
    chk("basic_busy_lit", 64'(b), 64'(16));
    chk("basic_count_lit", 64'(count), 64'(4));

    run("stall", 4, 16'hFFFB, 16'd300, 1, 5, 2, 1'b0, b);
    chk("stall_busy_lit", 64'(b), 64'(21));

    run("empty", 0, 16'd7, 16'd8, -1, 0, 2, 1'b0, b);
    chk("empty_busy_lit", 64'(b), 64'(1));

    run("timeout", 3, 16'd1, 16'd2, -1, 0, -1, 1'b0, b);
    chk("timeout_busy_lit", 64'(b), 64'(265));

    run("poke", 4, 16'd10, 16'd20, -1, 0, 2, 1'b1, b);
    chk("poke_busy_lit", 64'(b), 64'(16));

    run("edge_ok", 1, 16'h8000, 16'h7FFF, -1, 0, TO - 1, 1'b0, b);
    chk("edge_ok_busy_lit", 64'(b), 64'(259));
    run("edge_late", 1, 16'd3, 16'd4, -1, 0, TO, 1'b0, b);
    chk("edge_late_busy_lit", 64'(b), 64'(259));

    fill_mem(NMAX, 1'b1);
    run("saturate", 2047, 16'h1234, 16'hABCD, -1, 0, 0, 1'b0, b);
    chk("saturate_busy_lit", 64'(b), 64'(3074));
    chk("saturate_count_lit", 64'(count), 64'(1024));

    // Soft reset during READ of index 2.
    begin_run(4, 16'd10, 16'd20, -1, 0, 2);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (mem_en && mem_addr == 2) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("soft_reached_read2", 64'(found), 64'(1));
    soft_rst = 1'b1;
    @(posedge clk); #1 soft_rst = 1'b0;
    check_zero("soft");
    $display("abort soft_rst: busy=%0d count=%0d", busy, count);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset during ISSUE.
    begin_run(4, 16'd10, 16'd20, -1, 0, 2);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (srt_valid) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("arst_reached_issue", 64'(found), 64'(1));
    #1 rst = 1'b0;
    #1 check_zero("arst");
    $display("abort rst: busy=%0d count=%0d", busy, count);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;

    run("recover", 1, 16'd5, 16'd6, -1, 0, 0, 1'b0, b);
    chk("recover_busy_lit", 64'(b), 64'(5));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/knn_ctrl.md
Name: knn_ctrl

Overview:
Sequencer for the KNN sorter datapath. On a start pulse it latches the test point and clears the sorter. It then walks a training-point memory from index 0 to n_points-1 and presents each (test, training) coordinate pair to the sorter with a valid/ready handshake. After the last point it waits for the sorter's DONE and reports completion and error status to the KNN register file.

Parameters:
COORD_W, 16, width of one signed coordinate (X or Y)
MEM_ADDR_W, 10, training memory address width; max points = 2**MEM_ADDR_W
TIMEOUT, 255, max cycles in DRAIN waiting for srt_done before error (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
soft_rst  in  1  synchronous soft reset from KNN_RESET, active-high
start  in  1  one-cycle run request
n_points  in  MEM_ADDR_W+1  number of training points
test_x  in  COORD_W  test point X
test_y  in  COORD_W  test point Y
busy  out  1  run in progress
done  out  1  sticky run-complete flag
err_empty  out  1  last run had n_points==0
err_timeout  out  1  sorter DONE not seen within TIMEOUT
count  out  MEM_ADDR_W+1  points accepted by sorter this run
mem_en  out  1  training memory read enable
mem_addr  out  MEM_ADDR_W  training memory address
mem_rdata  in  2*COORD_W  {y,x}; valid exactly 1 cycle after mem_en
srt_clr  out  1  one-cycle sorter clear pulse
srt_valid  out  1  pair valid to sorter
srt_ready  in  1  sorter accepts pair
srt_x1, srt_y1  out  COORD_W each  latched test point
srt_x2, srt_y2  out  COORD_W each  training point
srt_idx  out  MEM_ADDR_W  index of presented training point
srt_last  out  1  presented pair is the final one
srt_done  in  1  sorter finished last insertion

Behaviour:
- Reset (rst low, async) and soft_rst (sync, high): all outputs 0, state IDLE, counters 0. soft_rst takes priority over start in the same cycle. No srt_clr is issued.
- States: IDLE, CLR, READ, LOAD, ISSUE, DRAIN.
- IDLE: on start, latch test_x/test_y into srt_x1/srt_y1. Latch n_eff = min(n_points, 2**MEM_ADDR_W). Clear done, err_*, count and idx. Go to CLR. busy=1 in every state except IDLE.
- start while busy is ignored, with no effect on state or latches.
- CLR: srt_clr=1 for exactly this cycle. If n_eff==0, set err_empty=1 and done=1, then go to IDLE. Otherwise go to READ.
- READ: mem_en=1, mem_addr=idx for one cycle. Go to LOAD.
- LOAD: capture mem_rdata[COORD_W-1:0] into srt_x2 and the upper half into srt_y2. Set srt_idx=idx and srt_last=(idx==n_eff-1). Go to ISSUE.
- ISSUE: srt_valid=1. srt_x2/srt_y2/srt_idx/srt_last are held stable until the handshake completes.
- A transfer occurs on a cycle with srt_valid & srt_ready. On transfer:
  - count+1 and srt_valid drops next cycle.
  - If srt_last, go to DRAIN; otherwise idx+1 and go to READ.
  - srt_ready while not in ISSUE is ignored.
- Minimum throughput is 3 cycles per point (READ, LOAD, ISSUE with srt_ready high).
- DRAIN: timer counts from 0.
  - srt_done=1 → done=1, go to IDLE.
  - Timer reaches TIMEOUT without srt_done → err_timeout=1, done=1, go to IDLE.
  - srt_done on the same cycle the timer hits TIMEOUT counts as success (no error).
- done, err_empty, err_timeout and count hold their values in IDLE until the next accepted start or reset.
- srt_clr, srt_valid and mem_en are all 0 in IDLE.
- n_points > 2**MEM_ADDR_W saturates; idx never wraps.
- Reset mid-run aborts immediately. No partial-run status is retained.

Test Plan:
- n_points=4, mem={y,x} = (1,2),(3,4),(5,6),(7,8), test=(10,20), srt_ready tied 1, srt_done 2 cycles after last transfer → one srt_clr; 4 transfers with srt_idx 0..3 and srt_last only on idx 3; count=4; done=1; no errors; busy for 1+12+3 cycles.
- Same as the first scenario, but srt_ready low for 5 cycles in ISSUE of idx 1 → pair (3,4) is held stable throughout the stall; only 4 transfers total.
- n_points=0 → srt_clr pulse, then done=1 and err_empty=1 after 2 cycles; mem_en never asserted; count=0.
- n_points=3, srt_done never asserted, TIMEOUT=255 → err_timeout=1 and done=1 after 255 DRAIN cycles; a new start clears both flags.
- start pulsed during ISSUE of idx 1 → ignored; run completes normally with count=4.
- soft_rst asserted during READ of idx 2 → next cycle IDLE with all outputs 0; rst low during ISSUE → outputs 0 asynchronously, before the next clk edge.
